// File: rtl/afe_parameters_pkg.sv
// Shared types and constants for the AFE TX streamer: FSM state encoding and
// the fixed uDMA transfer size code.
package afe_parameters_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } afe_tx_state_e;

  localparam logic [1:0] AFE_TX_SIZE_WORD = 2'b10;

endpackage

// File: rtl/afe_tx_fifo.sv
// Registered (non fall-through) output FIFO for the AFE TX streamer, with
// synchronous flush. Pushing while full is only accepted alongside a pop.
module afe_tx_fifo
  import afe_parameters_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_push,
  input  logic [DWIDTH-1:0]       i_data,
  input  logic                    i_pop,
  input  logic                    i_flush,
  output logic [DWIDTH-1:0]       o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == LP_DEPTH);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Output is gated so the data bus reads zero while nothing valid is held.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/afe_tx_streamer.sv
// Credit-based streamer reading words from L2 over uDMA into an AFE port.
// Define AFE_TX_STREAMER_CONT_EN to enable continuous (wrap-around) mode.
module afe_tx_streamer
  import afe_parameters_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned AFE_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_start_i,
  input  logic                      cfg_stop_i,
  input  logic                      cfg_cont_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_addr_i,
  input  logic [15:0]               cfg_words_i,
  output logic                      udma_tx_req_o,
  input  logic                      udma_tx_gnt_i,
  output logic [L2_AWIDTH_NOAL-1:0] udma_tx_addr_o,
  output logic [1:0]                udma_tx_size_o,
  input  logic                      udma_tx_valid_i,
  input  logic [AFE_DATA_WIDTH-1:0] udma_tx_data_i,
  output logic                      udma_tx_ready_o,
  output logic                      afe_valid_o,
  output logic [AFE_DATA_WIDTH-1:0] afe_data_o,
  input  logic                      afe_ready_i,
  output logic                      busy_o,
  output logic                      done_event_o
);

  localparam int unsigned               CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]               LP_DEPTH     = (CW+1)'(FIFO_DEPTH);
  localparam logic [L2_AWIDTH_NOAL-1:0] LP_ADDR_STEP = L2_AWIDTH_NOAL'(4);

  afe_tx_state_e             r_state;
  logic [L2_AWIDTH_NOAL-1:0] r_addr;
  logic [15:0]               r_remaining;
  logic [CW-1:0]             r_outstanding;
  logic                      r_abort;

  logic          w_cont;
  logic          w_credit;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_stop;
  logic          w_last;
  logic          w_wrap;
  logic          w_drain_done;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_inflight;

`ifdef AFE_TX_STREAMER_CONT_EN
  assign w_cont = cfg_cont_i;
`else
  logic w_unused_cont;
  assign w_unused_cont = cfg_cont_i;
  assign w_cont        = 1'b0;
`endif

  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit   = (w_inflight < LP_DEPTH);

  assign udma_tx_req_o   = (r_state == ST_REQ) && !r_abort && w_credit;
  assign udma_tx_addr_o  = r_addr;
  assign udma_tx_size_o  = AFE_TX_SIZE_WORD;
  assign udma_tx_ready_o = ~rst_i;
  assign busy_o          = (r_state != ST_IDLE);
  assign afe_valid_o     = ~w_fifo_empty;

  assign w_grant = udma_tx_req_o && udma_tx_gnt_i;
  // Responses with nothing outstanding (e.g. after reset) are accepted and dropped.
  assign w_rsp   = udma_tx_valid_i && (r_outstanding != '0);
  assign w_push  = w_rsp && !r_abort;
  assign w_pop   = afe_valid_o && afe_ready_i;
  assign w_stop  = cfg_stop_i && (r_state != ST_IDLE) && !r_abort;
  assign w_last  = w_grant && (r_remaining == 16'd1);
  assign w_wrap  = w_last && w_cont && !w_stop && (cfg_words_i != '0);

  assign w_drain_done = (r_state == ST_DRAIN) && !r_abort && !cfg_stop_i &&
                        (r_outstanding == '0) && w_fifo_empty;
  assign done_event_o = w_drain_done || w_wrap;

  afe_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DWIDTH (AFE_DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (udma_tx_data_i),
    .i_pop   (w_pop),
    .i_flush (w_stop),
    .o_data  (afe_data_o),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_abort       <= 1'b0;
    end else begin
      case ({w_grant, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (cfg_start_i && !cfg_stop_i && (cfg_words_i != '0)) begin
            r_state     <= ST_REQ;
            r_addr      <= cfg_addr_i;
            r_remaining <= cfg_words_i;
            r_abort     <= 1'b0;
          end
        end
        ST_REQ: begin
          if (w_grant) begin
            if (w_wrap) begin
              r_addr      <= cfg_addr_i;
              r_remaining <= cfg_words_i;
            end else begin
              r_addr      <= r_addr + LP_ADDR_STEP;
              r_remaining <= r_remaining - 16'd1;
              if (w_last) begin
                r_state <= ST_DRAIN;
              end
            end
          end
          // Abort reuses DRAIN: requests stop, in-flight responses are waited out.
          if (w_stop) begin
            r_state <= ST_DRAIN;
            r_abort <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_stop) begin
            r_abort <= 1'b1;
          end else if (r_abort) begin
            if (r_outstanding == '0) begin
              r_state <= ST_IDLE;
              r_abort <= 1'b0;
            end
          end else if (w_drain_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_tx_streamer.sv
// Scoreboard bench for afe_tx_streamer: expected request addresses and AFE
// words are queued by the stimulus and checked by an independent monitor.
module tb_afe_tx_streamer;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic        cfg_stop;
  logic        cfg_cont;
  logic [11:0] cfg_addr;
  logic [15:0] cfg_words;
  logic        udma_tx_req_o;
  logic        udma_tx_gnt_i;
  logic [11:0] udma_tx_addr_o;
  logic [1:0]  udma_tx_size_o;
  logic        udma_tx_valid_i;
  logic [31:0] udma_tx_data_i;
  logic        udma_tx_ready_o;
  logic        afe_valid_o;
  logic [31:0] afe_data_o;
  logic        afe_ready_i;
  logic        busy_o;
  logic        done_event_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned grant_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned rsp_lat = 1;
  logic        data_chk_en = 1'b1;

  logic [11:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  typedef struct {
    logic [11:0] a;
    int unsigned due;
  } rsp_t;
  rsp_t rq [$];

  afe_tx_streamer #(
    .L2_AWIDTH_NOAL (12),
    .AFE_DATA_WIDTH (32),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_start_i     (cfg_start),
    .cfg_stop_i      (cfg_stop),
    .cfg_cont_i      (cfg_cont),
    .cfg_addr_i      (cfg_addr),
    .cfg_words_i     (cfg_words),
    .udma_tx_req_o   (udma_tx_req_o),
    .udma_tx_gnt_i   (udma_tx_gnt_i),
    .udma_tx_addr_o  (udma_tx_addr_o),
    .udma_tx_size_o  (udma_tx_size_o),
    .udma_tx_valid_i (udma_tx_valid_i),
    .udma_tx_data_i  (udma_tx_data_i),
    .udma_tx_ready_o (udma_tx_ready_o),
    .afe_valid_o     (afe_valid_o),
    .afe_data_o      (afe_data_o),
    .afe_ready_i     (afe_ready_i),
    .busy_o          (busy_o),
    .done_event_o    (done_event_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {20'hCAFE0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] a0, input int unsigned n, input logic with_data);
    logic [11:0] a;
    a = a0;
    for (int unsigned i = 0; i < n; i++) begin
      exp_addr_q.push_back(a);
      if (with_data) exp_data_q.push_back(mem_word(a));
      a = a + 12'd4;
    end
  endtask

  task automatic start_xfer(input logic [11:0] a, input logic [15:0] w);
    @(negedge clk);
    cfg_addr  = a;
    cfg_words = w;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (busy_o && n < max_cyc);
    chk(name, busy_o, 1'b0);
  endtask

  task automatic wait_grants(input int unsigned target, input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant_cnt < target && n < max_cyc);
  endtask

  task automatic new_test();
    grant_cnt = 0;
    done_cnt  = 0;
  endtask

  // uDMA responder: returns mem_word(addr) rsp_lat cycles after each grant.
  initial begin
    udma_tx_valid_i = 1'b0;
    udma_tx_data_i  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        udma_tx_valid_i = 1'b1;
        udma_tx_data_i  = mem_word(rq[0].a);
        void'(rq.pop_front());
      end else begin
        udma_tx_valid_i = 1'b0;
        udma_tx_data_i  = '0;
      end
      if (udma_tx_req_o && udma_tx_gnt_i && !rst)
        rq.push_back('{a: udma_tx_addr_o, due: cyc + rsp_lat});
    end
  end

  // Monitor: sees the handshakes that complete at the next rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (udma_tx_req_o && udma_tx_gnt_i) begin
        grant_cnt++;
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_addr_unexpected: got %0h expected none", udma_tx_addr_o);
        end else begin
          chk("req_addr", udma_tx_addr_o, exp_addr_q.pop_front());
        end
      end
      if (afe_valid_o && afe_ready_i && data_chk_en) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL afe_unexpected: got %0h expected none", afe_data_o);
        end else begin
          chk("afe_data", afe_data_o, exp_data_q.pop_front());
        end
      end
      if (done_event_o) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    cfg_cont = 1'b0;
    cfg_addr = '0;
    cfg_words = '0;
    udma_tx_gnt_i = 1'b0;
    afe_ready_i = 1'b0;

    // Reset values
    @(negedge clk);
    #2;
    chk("rst_req", udma_tx_req_o, 1'b0);
    chk("rst_addr", udma_tx_addr_o, 12'h000);
    chk("rst_size", udma_tx_size_o, 2'b10);
    chk("rst_ready", udma_tx_ready_o, 1'b0);
    chk("rst_afe_valid", afe_valid_o, 1'b0);
    chk("rst_afe_data", afe_data_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_event_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("ready_after_rst", udma_tx_ready_o, 1'b1);

    // Basic 3-word transfer
    new_test();
    udma_tx_gnt_i = 1'b1;
    afe_ready_i = 1'b1;
    rsp_lat = 1;
    exp_addr_q.push_back(12'h100);
    exp_addr_q.push_back(12'h104);
    exp_addr_q.push_back(12'h108);
    exp_data_q.push_back(32'hCAFE0100);
    exp_data_q.push_back(32'hCAFE0104);
    exp_data_q.push_back(32'hCAFE0108);
    start_xfer(12'h100, 16'd3);
    #2;
    chk("t1_busy", busy_o, 1'b1);
    wait_idle("t1_idle", 100);
    chk("t1_grants", grant_cnt, 3);
    chk("t1_done", done_cnt, 1);
    chk("t1_addr_left", exp_addr_q.size(), 0);
    chk("t1_data_left", exp_data_q.size(), 0);

    // Zero-length start and start+stop in IDLE are ignored
    new_test();
    start_xfer(12'h600, 16'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("t0len_busy", busy_o, 1'b0);
    @(negedge clk);
    cfg_addr = 12'h640;
    cfg_words = 16'd1;
    cfg_start = 1'b1;
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("tss_busy", busy_o, 1'b0);
    chk("tss_grants", grant_cnt, 0);

    // AFE stall: credit limits grants to the FIFO depth
    new_test();
    afe_ready_i = 1'b0;
    push_exp(12'h200, 8, 1'b1);
    start_xfer(12'h200, 16'd8);
    repeat (10) @(negedge clk);
    start_xfer(12'h300, 16'd1);
    repeat (10) @(negedge clk);
    #2;
    chk("t2_stall_grants", grant_cnt, 4);
    chk("t2_stall_req", udma_tx_req_o, 1'b0);
    chk("t2_stall_valid", afe_valid_o, 1'b1);
    chk("t2_stall_busy", busy_o, 1'b1);
    chk("t2_stall_done", done_cnt, 0);
    @(negedge clk);
    afe_ready_i = 1'b1;
    wait_idle("t2_idle", 200);
    chk("t2_grants", grant_cnt, 8);
    chk("t2_done", done_cnt, 1);
    chk("t2_addr_left", exp_addr_q.size(), 0);
    chk("t2_data_left", exp_data_q.size(), 0);

    // Address wrap at top of the L2 window
    new_test();
    exp_addr_q.push_back(12'hFFC);
    exp_addr_q.push_back(12'h000);
    exp_data_q.push_back(32'hCAFE0FFC);
    exp_data_q.push_back(32'hCAFE0000);
    start_xfer(12'hFFC, 16'd2);
    wait_idle("t3_idle", 100);
    chk("t3_grants", grant_cnt, 2);
    chk("t3_done", done_cnt, 1);
    chk("t3_data_left", exp_data_q.size(), 0);

    // Stop with one response outstanding
    new_test();
    afe_ready_i = 1'b0;
    rsp_lat = 1;
    exp_addr_q.push_back(12'h400);
    exp_addr_q.push_back(12'h404);
    start_xfer(12'h400, 16'd5);
    wait_grants(1, 50);
    rsp_lat = 8;
    wait_grants(2, 50);
    udma_tx_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("t4_pre_req", udma_tx_req_o, 1'b1);
    chk("t4_pre_valid", afe_valid_o, 1'b1);
    pulse_stop();
    #2;
    chk("t4_req_dropped", udma_tx_req_o, 1'b0);
    chk("t4_flushed", afe_valid_o, 1'b0);
    chk("t4_busy_wait", busy_o, 1'b1);
    afe_ready_i = 1'b1;
    wait_idle("t4_idle", 50);
    repeat (3) @(negedge clk);
    #2;
    chk("t4_grants", grant_cnt, 2);
    chk("t4_done", done_cnt, 0);
    chk("t4_valid_after", afe_valid_o, 1'b0);
    rsp_lat = 1;
    udma_tx_gnt_i = 1'b1;

    // Continuous mode
    new_test();
    cfg_cont = 1'b1;
`ifdef AFE_TX_STREAMER_CONT_EN
    data_chk_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(12'h020);
      exp_addr_q.push_back(12'h024);
    end
    start_xfer(12'h020, 16'd2);
    wait_grants(6, 200);
    cfg_stop = 1'b1;
    chk("t5_grants", grant_cnt, 6);
    chk("t5_done_wraps", done_cnt, 3);
    @(negedge clk);
    cfg_stop = 1'b0;
    wait_idle("t5_idle", 100);
    chk("t5_done_after_stop", done_cnt, 3);
    exp_addr_q.delete();
    data_chk_en = 1'b1;
`else
    exp_addr_q.push_back(12'h020);
    exp_addr_q.push_back(12'h024);
    exp_data_q.push_back(32'hCAFE0020);
    exp_data_q.push_back(32'hCAFE0024);
    start_xfer(12'h020, 16'd2);
    wait_idle("t5_idle", 100);
    chk("t5_grants", grant_cnt, 2);
    chk("t5_done", done_cnt, 1);
    chk("t5_data_left", exp_data_q.size(), 0);
`endif
    cfg_cont = 1'b0;

    // Reset mid-transfer; late responses must be discarded
    new_test();
    afe_ready_i = 1'b0;
    rsp_lat = 3;
    push_exp(12'h500, 4, 1'b0);
    start_xfer(12'h500, 16'd4);
    wait_grants(2, 50);
    rst = 1'b1;
    #2;
    chk("t6_rst_req", udma_tx_req_o, 1'b0);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_valid", afe_valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    afe_ready_i = 1'b1;
    exp_addr_q.delete();
    repeat (8) @(negedge clk);
    #2;
    chk("t6_grants", grant_cnt, 2);
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_valid", afe_valid_o, 1'b0);
    chk("t6_ready", udma_tx_ready_o, 1'b1);
    chk("t6_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
